// File: rtl/sa_operand_feeder_pkg.sv
// Shared systolic-array definitions: feeder FSM states, SRAM read latency and
// the flush-length rule used to drain the skewed lane pipeline.
package sa_operand_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  localparam int SRAM_RD_LATENCY = 1;

  // Cycles from the last read until the slowest lane has presented its final
  // beat: SRAM latency, one lane-0 register, plus the deepest skew line.
  function automatic int flush_len(input int num_lane, input int skew_en);
    return SRAM_RD_LATENCY + 1 + ((skew_en != 0) ? (num_lane - 1) : 0);
  endfunction

endpackage

// File: rtl/sa_operand_feeder_if.sv
// Command, SRAM read port and array-side lane bus of the operand feeder.
// master = host/SRAM side, slave = feeder.
interface sa_operand_feeder_if #(
  parameter int NUM_LANE             = 8,
  parameter int DATA_WIDTH           = 8,
  parameter int LOG2_SRAM_BANK_DEPTH = 10
);

  logic                             i_start;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]  i_rd_start_addr;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]  i_rd_end_addr;
  logic                             o_sram_rd_en;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_sram_rd_addr;
  logic [NUM_LANE*DATA_WIDTH-1:0]   i_sram_rd_data;
  logic [NUM_LANE-1:0]              o_valid;
  logic [NUM_LANE*DATA_WIDTH-1:0]   o_data;
  logic                             o_busy;
  logic                             o_done;

  modport master (
    output i_start, i_rd_start_addr, i_rd_end_addr, i_sram_rd_data,
    input  o_sram_rd_en, o_sram_rd_addr, o_valid, o_data, o_busy, o_done
  );

  modport slave (
    input  i_start, i_rd_start_addr, i_rd_end_addr, i_sram_rd_data,
    output o_sram_rd_en, o_sram_rd_addr, o_valid, o_data, o_busy, o_done
  );

endinterface

// File: rtl/sa_skew_delay_line.sv
// Fixed-depth delay of a valid/data pair; data only advances alongside a valid
// beat, so the output holds its last operand between beats.
module sa_skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             dly_valid,
  output logic [WIDTH-1:0] dly_data
);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q[0] <= src_valid;
      if (src_valid) data_q[0] <= src_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign dly_valid = vld_q[DEPTH-1];
  assign dly_data  = data_q[DEPTH-1];

endmodule

// File: rtl/sa_operand_feeder.sv
// Streams an inclusive SRAM address range into the systolic array edge,
// optionally skewing lane k by k cycles to form the diagonal wavefront.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for i_start; outputs quiet
// ST_READ  | one SRAM read per cycle, address wraps at bank depth
// ST_FLUSH | reads finished, draining SRAM latency and skew lines
// ST_DONE  | one-cycle o_done pulse, i_start ignored
module sa_operand_feeder
  import sa_operand_feeder_pkg::*;
#(
  parameter int NUM_LANE             = 8,
  parameter int DATA_WIDTH           = 8,
  parameter int LOG2_SRAM_BANK_DEPTH = 10,
  parameter int SKEW_EN              = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sa_operand_feeder_if.slave  bus
);

  localparam int AW          = LOG2_SRAM_BANK_DEPTH;
  localparam int LW          = NUM_LANE * DATA_WIDTH;
  localparam int FLUSH_LEN   = flush_len(NUM_LANE, SKEW_EN);
  localparam int FLUSH_CNT_W = (FLUSH_LEN > 2) ? $clog2(FLUSH_LEN) : 1;

  feeder_state_e          state;
  logic [AW-1:0]          rd_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic                   rd_en_q;
  logic [AW-1:0]          rd_addr_q;
  logic                   busy_q;
  logic                   done_q;

  // rd_cnt holds reads remaining after the current one, so the end address is
  // captured as (end - start) modulo the bank depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rd_cnt    <= '0;
      flush_cnt <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            state     <= ST_READ;
            rd_en_q   <= 1'b1;
            rd_addr_q <= bus.i_rd_start_addr;
            rd_cnt    <= bus.i_rd_end_addr - bus.i_rd_start_addr;
            busy_q    <= 1'b1;
          end
        end
        ST_READ: begin
          if (rd_cnt == '0) begin
            state     <= ST_FLUSH;
            rd_en_q   <= 1'b0;
            flush_cnt <= FLUSH_CNT_W'(FLUSH_LEN - 1);
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
            rd_cnt    <= rd_cnt - 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [SRAM_RD_LATENCY-1:0] rd_pipe;
  logic                       stage0_valid;
  logic [LW-1:0]              stage0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe      <= '0;
      stage0_valid <= 1'b0;
      stage0_data  <= '0;
    end else begin
      rd_pipe[0] <= rd_en_q;
      for (int i = 1; i < SRAM_RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      stage0_valid <= rd_pipe[SRAM_RD_LATENCY-1];
      if (rd_pipe[SRAM_RD_LATENCY-1]) stage0_data <= bus.i_sram_rd_data;
    end
  end

  logic [NUM_LANE-1:0] lane_valid;
  logic [LW-1:0]       lane_data;

  for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
    if (SKEW_EN != 0 && k > 0) begin : g_skew
      sa_skew_delay_line #(
        .DEPTH (k),
        .WIDTH (DATA_WIDTH)
      ) u_dly (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (stage0_valid),
        .src_data  (stage0_data[k*DATA_WIDTH +: DATA_WIDTH]),
        .dly_valid (lane_valid[k]),
        .dly_data  (lane_data[k*DATA_WIDTH +: DATA_WIDTH])
      );
    end else begin : g_direct
      assign lane_valid[k]                            = stage0_valid;
      assign lane_data[k*DATA_WIDTH +: DATA_WIDTH]    = stage0_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.o_sram_rd_en   = rd_en_q;
  assign bus.o_sram_rd_addr = rd_addr_q;
  assign bus.o_valid        = lane_valid;
  assign bus.o_data         = lane_data;
  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Bench for sa_operand_feeder: skewed and aligned instances checked cycle by
// cycle against a per-read timing model with a behavioural SRAM.
module tb_sa_operand_feeder;

  localparam int NL    = 4;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int LW    = NL * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_operand_feeder_if #(.NUM_LANE(NL), .DATA_WIDTH(DW), .LOG2_SRAM_BANK_DEPTH(AW)) bus_sk ();
  sa_operand_feeder_if #(.NUM_LANE(NL), .DATA_WIDTH(DW), .LOG2_SRAM_BANK_DEPTH(AW)) bus_al ();

  sa_operand_feeder #(.NUM_LANE(NL), .DATA_WIDTH(DW), .LOG2_SRAM_BANK_DEPTH(AW), .SKEW_EN(1))
    u_dut_sk (.clk(clk), .rst_n(rst_n), .bus(bus_sk.slave));
  sa_operand_feeder #(.NUM_LANE(NL), .DATA_WIDTH(DW), .LOG2_SRAM_BANK_DEPTH(AW), .SKEW_EN(0))
    u_dut_al (.clk(clk), .rst_n(rst_n), .bus(bus_al.slave));

  logic [LW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (bus_sk.o_sram_rd_en) bus_sk.i_sram_rd_data <= mem[bus_sk.o_sram_rd_addr];
    if (bus_al.o_sram_rd_en) bus_al.i_sram_rd_data <= mem[bus_al.o_sram_rd_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] last_data [2][NL];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic sample(input int d, output logic rd_en, output logic [AW-1:0] addr,
                        output logic [NL-1:0] vld, output logic [LW-1:0] data,
                        output logic busy, output logic done);
    if (d == 0) begin
      rd_en = bus_sk.o_sram_rd_en; addr = bus_sk.o_sram_rd_addr; vld = bus_sk.o_valid;
      data = bus_sk.o_data; busy = bus_sk.o_busy; done = bus_sk.o_done;
    end else begin
      rd_en = bus_al.o_sram_rd_en; addr = bus_al.o_sram_rd_addr; vld = bus_al.o_valid;
      data = bus_al.o_data; busy = bus_al.o_busy; done = bus_al.o_done;
    end
  endtask

  task automatic drive(input int d, input logic st, input int s, input int e);
    if (d == 0) begin
      bus_sk.i_start = st; bus_sk.i_rd_start_addr = AW'(s); bus_sk.i_rd_end_addr = AW'(e);
    end else begin
      bus_al.i_start = st; bus_al.i_rd_start_addr = AW'(s); bus_al.i_rd_end_addr = AW'(e);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NL; k++) last_data[d][k] = '0;
  endtask

  task automatic check_quiet(input string tag);
    logic rd_en, busy, done;
    logic [AW-1:0] addr;
    logic [NL-1:0] vld;
    logic [LW-1:0] data;
    for (int d = 0; d < 2; d++) begin
      sample(d, rd_en, addr, vld, data, busy, done);
      check_val($sformatf("%s d%0d rd_en", tag, d), 64'(rd_en), 64'd0);
      check_val($sformatf("%s d%0d rd_addr", tag, d), 64'(addr), 64'd0);
      check_val($sformatf("%s d%0d valid", tag, d), 64'(vld), 64'd0);
      check_val($sformatf("%s d%0d data", tag, d), 64'(data), 64'd0);
      check_val($sformatf("%s d%0d busy", tag, d), 64'(busy), 64'd0);
      check_val($sformatf("%s d%0d done", tag, d), 64'(done), 64'd0);
    end
  endtask

  // Stream [s..e] through dut d (0 = skewed, 1 = aligned). extra re-pulses
  // i_start in READ and DONE; rst_at > 0 asserts reset at that cycle.
  task automatic run_stream(input int d, input int s, input int e, input bit extra, input int rst_at);
    int n, done_c, off, j, idx;
    bit skew;
    logic rd_en, busy, done;
    logic [AW-1:0] addr;
    logic [NL-1:0] vld, exp_vld;
    logic [LW-1:0] data, exp_data, word;
    skew   = (d == 0);
    n      = ((e - s + DEPTH) % DEPTH) + 1;
    done_c = 1 + n + 2 + (skew ? NL - 1 : 0);
    drive(d, 1'b1, s, e);
    @(posedge clk);
    #1;
    drive(d, 1'b0, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)));
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      sample(d, rd_en, addr, vld, data, busy, done);
      check_val($sformatf("d%0d s%0d c%0d rd_en", d, s, c), 64'(rd_en), 64'(c >= 1 && c <= n));
      if (c <= n)
        check_val($sformatf("d%0d s%0d c%0d rd_addr", d, s, c), 64'(addr), 64'((s + c - 1) % DEPTH));
      for (int k = 0; k < NL; k++) begin
        off        = 3 + (skew ? k : 0);
        j          = c - off;
        exp_vld[k] = (j >= 0 && j < n);
        if (exp_vld[k]) begin
          idx              = (s + j) % DEPTH;
          word             = mem[idx];
          last_data[d][k]  = word[k*DW +: DW];
        end
        exp_data[k*DW +: DW] = last_data[d][k];
      end
      check_val($sformatf("d%0d s%0d c%0d valid", d, s, c), 64'(vld), 64'(exp_vld));
      check_val($sformatf("d%0d s%0d c%0d data", d, s, c), 64'(data), 64'(exp_data));
      check_val($sformatf("d%0d s%0d c%0d done", d, s, c), 64'(done), 64'(c == done_c));
      if (c != done_c)
        check_val($sformatf("d%0d s%0d c%0d busy", d, s, c), 64'(busy), 64'(c < done_c));
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        clear_model();
        check_quiet($sformatf("rst_in_flush c%0d", c));
        drive(d, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 12; r++) begin
          @(negedge clk);
          check_quiet($sformatf("post_rst r%0d", r));
        end
        return;
      end
      if (extra && (c == 2 || c == done_c))
        drive(d, 1'b1, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)));
      else
        drive(d, 1'b0, 0, 0);
    end
  endtask

  initial begin
    int d, s, len;
    for (int i = 0; i < DEPTH; i++) mem[i] = LW'($urandom);
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    clear_model();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("after_reset");

    run_stream(0, 5, 8, 1'b0, 0);
    run_stream(0, 1022, 1, 1'b0, 0);
    run_stream(1, 1022, 1, 1'b0, 0);
    run_stream(1, 7, 7, 1'b0, 0);
    run_stream(0, 7, 7, 1'b0, 0);
    run_stream(0, 100, 105, 1'b1, 0);
    run_stream(1, 100, 105, 1'b1, 0);
    run_stream(0, 200, 203, 1'b0, 6);
    run_stream(0, 300, 302, 1'b0, 0);
    run_stream(0, 301, 301, 1'b0, 0);

    for (int it = 0; it < 24; it++) begin
      d   = int'($urandom_range(0, 1));
      s   = int'($urandom_range(0, DEPTH - 1));
      len = int'($urandom_range(1, 9));
      run_stream(d, s, (s + len - 1) % DEPTH, 1'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
